sym_game_ctrl: RTL and testbench

Round sequencer for the symbol-counting game. It enables the symbol generator during a timed play window and sets the generator's interval. It counts the special symbols the generator reports, then collects the player's guess from push-buttons. It compares the guess against the true count, shows a win/lose result for a fixed time, and returns to idle.

---
 rtl/sym_game_ctrl.sv | 143 ++++++++++++++
 tb/tb_sym_game_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sym_game_ctrl.sv
// rtl/sym_game_ctrl.sv - round sequencer for the symbol-counting game
// Optional randomized generator interval: define SYM_RAND_INTERVAL_EN.
module sym_game_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int PLAY_TICKS   = 20000,
  parameter int RESULT_TICKS = 3000,
  parameter int GEN_MAX      = 200
`ifdef SYM_RAND_INTERVAL_EN
  ,
  parameter int GEN_MAX_MIN  = 100
`endif
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       startBtn,
  input  logic       incBtn,
  input  logic       decBtn,
  input  logic       submitBtn,
  input  logic       generated,
  input  logic       special,
  output logic       genSym,
  output logic [7:0] symGenMax,
  output logic [7:0] specialCount,
  output logic [7:0] guess,
  output logic [1:0] state,
  output logic       win,
  output logic       lose
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_GUESS  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TICK_MX = (PLAY_TICKS > RESULT_TICKS) ? PLAY_TICKS : RESULT_TICKS;
  localparam int TICK_W  = $clog2(TICK_MX + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] PLAY_LAST   = TICK_W'(PLAY_TICKS - 1);
  localparam logic [TICK_W-1:0] RESULT_LAST = TICK_W'(RESULT_TICKS - 1);

  logic [PRE_W-1:0]  pre;
  logic [TICK_W-1:0] ticks;
  logic [1:0]        state_nx;
  logic              tick;
  logic              running;

`ifdef SYM_RAND_INTERVAL_EN
  logic [7:0] lfsr;
  logic [7:0] rand_max;
  assign rand_max = 8'(GEN_MAX_MIN) + {2'b00, lfsr[5:0]};
`endif

  always_comb begin
    running  = (state == S_PLAY) || (state == S_RESULT);
    tick     = running && (pre == PRE_LAST);
    state_nx = state;
    case (state)
      S_IDLE:   if (startBtn) state_nx = S_PLAY;
      S_PLAY:   if (tick && ticks == PLAY_LAST) state_nx = S_GUESS;
      S_GUESS:  if (submitBtn) state_nx = S_RESULT;
      default:  if (tick && ticks == RESULT_LAST) state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= S_IDLE;
      genSym       <= 1'b0;
      specialCount <= 8'd0;
      guess        <= 8'd0;
      win          <= 1'b0;
      lose         <= 1'b0;
      symGenMax    <= 8'(GEN_MAX);
      pre          <= '0;
      ticks        <= '0;
`ifdef SYM_RAND_INTERVAL_EN
      lfsr         <= 8'hA5;
`endif
    end else begin
      state  <= state_nx;
      genSym <= (state_nx == S_PLAY);

      // Timebase restarts from zero in every state so each window is exact.
      if (state_nx != state) begin
        pre   <= '0;
        ticks <= '0;
      end else if (tick) begin
        pre   <= '0;
        ticks <= ticks + TICK_W'(1);
      end else if (running) begin
        pre   <= pre + PRE_W'(1);
      end

`ifdef SYM_RAND_INTERVAL_EN
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif

      case (state)
        S_IDLE: begin
          if (startBtn) begin
            specialCount <= 8'd0;
            guess        <= 8'd0;
            win          <= 1'b0;
            lose         <= 1'b0;
`ifdef SYM_RAND_INTERVAL_EN
            symGenMax    <= rand_max;
`endif
          end
        end
        S_PLAY: begin
          if (generated && special && specialCount != 8'hFF)
            specialCount <= specialCount + 8'd1;
`ifdef SYM_RAND_INTERVAL_EN
          if (generated) symGenMax <= rand_max;
`endif
        end
        S_GUESS: begin
          // Submit wins over a simultaneous inc/dec and judges the held guess.
          if (submitBtn) begin
            win  <= (guess == specialCount);
            lose <= (guess != specialCount);
          end else if (incBtn && !decBtn && guess != 8'hFF) begin
            guess <= guess + 8'd1;
          end else if (decBtn && !incBtn && guess != 8'h00) begin
            guess <= guess - 8'd1;
          end
        end
        default: begin
          if (state_nx == S_IDLE) begin
            win  <= 1'b0;
            lose <= 1'b0;
`ifdef SYM_RAND_INTERVAL_EN
            symGenMax <= 8'(GEN_MAX);
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sym_game_ctrl.sv
// tb/tb_sym_game_ctrl.sv - directed self-checking bench for sym_game_ctrl
module tb_sym_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn, inc_btn, dec_btn, submit_btn, generated, special;
  logic       gen_sym, win, lose;
  logic [7:0] sym_gen_max, special_count, guess;
  logic [1:0] state;

  int vectors = 0;
  int errors  = 0;

  sym_game_ctrl #(
    .TICK_DIV(4), .PLAY_TICKS(10), .RESULT_TICKS(3), .GEN_MAX(200)
  ) dut (
    .Clk100M(clk), .Rst_n(rst_n),
    .startBtn(start_btn), .incBtn(inc_btn), .decBtn(dec_btn), .submitBtn(submit_btn),
    .generated(generated), .special(special),
    .genSym(gen_sym), .symGenMax(sym_gen_max), .specialCount(special_count),
    .guess(guess), .state(state), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
`ifdef SYM_RAND_INTERVAL_EN
    vectors++;
    assert (sym_gen_max >= 8'd100 && sym_gen_max <= 8'd163 || sym_gen_max == 8'd200)
      else begin
        errors++;
        $error("FAIL sym_gen_max_range observed=%0d expected=100..163", sym_gen_max);
      end
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_round();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic pulse_inc();
    inc_btn = 1'b1;
    step();
    inc_btn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {start_btn, inc_btn, dec_btn, submit_btn, generated, special} = '0;
    steps(3);
    rst_n = 1'b1;
    step();

    check("rst_state", state, 0);
    check("rst_gensym", gen_sym, 0);
    check("rst_count", special_count, 0);
    check("rst_guess", guess, 0);
    check("rst_win", win, 0);
    check("rst_lose", lose, 0);
`ifndef SYM_RAND_INTERVAL_EN
    check("rst_genmax", sym_gen_max, 200);
`endif

    // Round 1: timing, counting, win
    start_round();
    check("play_state", state, 1);
    check("play_gensym", gen_sym, 1);
    for (int i = 0; i < 39; i++) begin
      generated = (i < 7);
      special   = (i < 5);
      step();
    end
    generated = 1'b0;
    special   = 1'b0;
    check("play_still_39", state, 1);
    step();
    check("guess_state_40", state, 2);
    check("guess_gensym", gen_sym, 0);
    check("count_5", special_count, 5);
    for (int i = 0; i < 5; i++) pulse_inc();
    check("guess_5", guess, 5);
    submit_btn = 1'b1;
    step();
    submit_btn = 1'b0;
    check("result_state", state, 3);
    check("result_win", win, 1);
    check("result_lose", lose, 0);
    steps(11);
    check("result_still_11", state, 3);
    step();
    check("idle_after_12", state, 0);
    check("idle_win_clr", win, 0);
    check("idle_count_held", special_count, 5);
    check("idle_guess_held", guess, 5);

    // Round 2: saturation, ignored start, loss
    start_round();
    check("r2_guess_cleared", guess, 0);
    steps(40);
    check("r2_guess_state", state, 2);
    dec_btn = 1'b1;
    step();
    dec_btn = 1'b0;
    check("dec_sat_0", guess, 0);
    for (int i = 0; i < 300; i++) pulse_inc();
    check("inc_sat_255", guess, 255);
    inc_btn = 1'b1;
    dec_btn = 1'b1;
    step();
    {inc_btn, dec_btn} = 2'b00;
    check("inc_dec_same", guess, 255);
    start_round();
    check("start_ignored_guess", state, 2);
    submit_btn = 1'b1;
    inc_btn    = 1'b1;
    step();
    {submit_btn, inc_btn} = 2'b00;
    check("r2_result_state", state, 3);
    check("r2_lose", lose, 1);
    check("r2_win", win, 0);
    check("r2_guess_pre_inc", guess, 255);
    steps(12);
    check("r2_idle", state, 0);
    check("r2_lose_clr", lose, 0);

    // Round 3: special pulse in the final PLAY cycle
    start_round();
    steps(39);
    check("r3_play_39", state, 1);
    generated = 1'b1;
    special   = 1'b1;
    step();
    {generated, special} = 2'b00;
    check("r3_guess_on_time", state, 2);
    check("r3_last_counted", special_count, 1);
    submit_btn = 1'b1;
    step();
    submit_btn = 1'b0;
    steps(12);

    // Round 4: asynchronous reset mid-PLAY
    start_round();
    for (int i = 0; i < 3; i++) begin
      {generated, special} = 2'b11;
      step();
    end
    {generated, special} = 2'b00;
    check("r4_count_3", special_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_gensym", gen_sym, 0);
    check("arst_count", special_count, 0);
    check("arst_guess", guess, 0);
    check("arst_win_lose", {30'd0, win, lose}, 0);
    check("arst_genmax", sym_gen_max, 200);
    step();
    rst_n = 1'b1;
    steps(5);
    check("post_rst_idle", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
